// File: rtl/seven_seg_frame_streamer.sv
// seven_seg_frame_streamer
//
// Purpose:
//   Renders a row of NUM_DIGITS seven-segment digits into one complete
//   SSD1306 page-ordered frame (PAGES x COLUMNS bytes). For every column it
//   addresses an external combinational 21x32 glyph decoder with the digit's
//   segments, the column within the glyph and the current page. It then
//   registers the returned pixel byte into a valid/ready byte stream that
//   feeds the display transport.
//
// Ports:
//   clk_in          clock
//   reset_in        synchronous, active-high reset
//   start_in        frame request, only looked at while idle
//   segments_in     {g..a} per digit, digit d = [7d+6:7d], latched on start
//   seg_out         segments of the digit being addressed (to decoder)
//   index_x_out     column inside the glyph, 0..20 (to decoder)
//   index_y_out     current page (to decoder)
//   pixels_in       decoder result for seg_out/index_x_out/index_y_out
//   data_out        column byte, bit0 = top row of the page
//   data_valid_out  data_out is valid
//   data_ready_in   transport takes the byte when valid && ready
//   page_start_out  data_out is column 0 of a page
//   busy_out        a frame is being streamed
//   done_out        one-cycle pulse after the last byte is accepted

module seven_seg_frame_streamer #(
    parameter int NUM_DIGITS = 5,
    parameter int GAP_COLS   = 3,
    parameter int LEFT_PAD   = 5,
    parameter int COLUMNS    = 128,
    parameter int PAGES      = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic [7*NUM_DIGITS-1:0] segments_in,
    output logic [6:0]              seg_out,
    output logic [4:0]              index_x_out,
    output logic [1:0]              index_y_out,
    input  logic [7:0]              pixels_in,
    output logic [7:0]              data_out,
    output logic                    data_valid_out,
    input  logic                    data_ready_in,
    output logic                    page_start_out,
    output logic                    busy_out,
    output logic                    done_out
);

    localparam int GLYPH_W = 21;
    localparam int PITCH   = GLYPH_W + GAP_COLS;
    localparam int CW      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int XW      = $clog2(PITCH);
    localparam int DW      = $clog2(NUM_DIGITS + 1);

    if (LEFT_PAD + GLYPH_W*NUM_DIGITS + GAP_COLS*(NUM_DIGITS-1) > COLUMNS) begin : g_bad_geometry
        $error("seven_seg_frame_streamer: digits do not fit in COLUMNS");
    end

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [1:0]              page_q, page_d;
    logic [XW-1:0]           x_q, x_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [7*NUM_DIGITS-1:0] latch_q, latch_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    page_start_q, page_start_d;
    logic                    last_q, last_d;

    logic [7*NUM_DIGITS-1:0] seg_src;
    logic [6:0]              sel_seg;
    logic                    in_pad;
    logic                    in_digit;
    logic                    last_col;
    logic                    last_page;
    logic                    load;

    // While idle the first byte is produced on the same edge that accepts
    // start, so the decoder has to see the incoming segments rather than the
    // (not yet written) latch.
    always_comb begin
        seg_src   = (state_q == IDLE) ? segments_in : latch_q;
        in_pad    = (col_q < CW'(LEFT_PAD));
        in_digit  = !in_pad && (digit_q < DW'(NUM_DIGITS)) && (x_q < XW'(GLYPH_W));
        last_col  = (col_q == CW'(COLUMNS - 1));
        last_page = (page_q == 2'(PAGES - 1));
    end

    // Digit select without a variable part-select on an out-of-range index.
    always_comb begin
        sel_seg = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                sel_seg = seg_src[7*i +: 7];
            end
        end
    end

    // Outside a glyph the decoder address is parked at zero.
    always_comb begin
        seg_out     = in_digit ? sel_seg : 7'd0;
        index_x_out = in_digit ? 5'(x_q) : 5'd0;
        index_y_out = page_q;
    end

    // Next-state logic. Column/digit counters only move when a byte is
    // loaded into the output register. x counts through glyph plus gap and
    // then bumps the digit counter, which saturates at NUM_DIGITS so the
    // trailing blank columns never alias onto a digit.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        page_d       = page_q;
        x_d          = x_q;
        digit_d      = digit_q;
        latch_d      = latch_q;
        data_d       = data_q;
        valid_d      = valid_q;
        page_start_d = page_start_q;
        last_d       = last_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    latch_d = segments_in;
                    state_d = STREAM;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (!valid_q || data_ready_in) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                col_d   = '0;
                page_d  = '0;
                x_d     = '0;
                digit_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            data_d       = in_digit ? pixels_in : 8'd0;
            valid_d      = 1'b1;
            page_start_d = (col_q == '0);
            last_d       = last_col && last_page;
            if (last_col) begin
                col_d   = '0;
                page_d  = page_q + 2'd1;
                x_d     = '0;
                digit_d = '0;
            end else begin
                col_d = col_q + CW'(1);
                if (!in_pad) begin
                    if (x_q == XW'(PITCH - 1)) begin
                        x_d = '0;
                        if (digit_q != DW'(NUM_DIGITS)) begin
                            digit_d = digit_q + DW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            col_q        <= '0;
            page_q       <= '0;
            x_q          <= '0;
            digit_q      <= '0;
            latch_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            page_start_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            page_q       <= page_d;
            x_q          <= x_d;
            digit_q      <= digit_d;
            latch_q      <= latch_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            page_start_q <= page_start_d;
            last_q       <= last_d;
        end
    end

    always_comb begin
        data_out       = data_q;
        data_valid_out = valid_q;
        page_start_out = page_start_q;
        busy_out       = (state_q == STREAM);
        done_out       = (state_q == DONE);
    end

endmodule

// File: tb/tb_seven_seg_frame_streamer.sv
// tb_seven_seg_frame_streamer
//
// Purpose:
//   Directed testbench for seven_seg_frame_streamer with a stub glyph
//   decoder that returns a {1, page, x} marker for any lit digit and zero
//   for a blank digit. Captured frames are compared with a division-based
//   reference of the column layout.

module tb_seven_seg_frame_streamer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [34:0] segments_in;
    logic [6:0]  seg_out;
    logic [4:0]  index_x_out;
    logic [1:0]  index_y_out;
    logic [7:0]  pixels_in;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        data_ready_in;
    logic        page_start_out;
    logic        busy_out;
    logic        done_out;

    int check_count = 0;
    int error_count = 0;

    logic [7:0] cap_data [512];
    logic       cap_ps   [512];
    int         byte_cnt;
    int         done_sample;
    int         last_sample;
    int         first_valid_sample;
    int         stall_viol;
    logic       aborted;

    seven_seg_frame_streamer dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .start_in       (start_in),
        .segments_in    (segments_in),
        .seg_out        (seg_out),
        .index_x_out    (index_x_out),
        .index_y_out    (index_y_out),
        .pixels_in      (pixels_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .page_start_out (page_start_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    // 100 MHz style free-running clock.
    always #5 clk_in = ~clk_in;

    // Stub decoder: blank digit gives an empty column, lit digit gives a
    // marker encoding the requested page and glyph column.
    always_comb begin
        pixels_in = (seg_out == 7'd0) ? 8'd0 : {1'b1, index_y_out, index_x_out};
    end

    // Step to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference column layout: pad 5, glyphs of 21, pitch 24, 128 columns.
    function automatic logic [7:0] expByte(input int idx, input logic [34:0] segs);
        int p;
        int c;
        int k;
        int d;
        int x;
        p = idx / 128;
        c = idx % 128;
        if (c < 5) return 8'd0;
        k = c - 5;
        d = k / 24;
        x = k % 24;
        if (d >= 5 || x >= 21) return 8'd0;
        if (segs[7*d +: 7] == 7'd0) return 8'd0;
        return {1'b1, p[1:0], x[4:0]};
    endfunction

    // Issue a one-cycle start with the given digits; leaves the bench at the
    // first sample point after the accepting edge.
    task automatic applyStimulus(input logic [34:0] segs);
        segments_in   = segs;
        start_in      = 1'b1;
        data_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    // Drive ready and capture accepted bytes until done_out, the cycle
    // budget runs out, or a reset is injected at byte abort_at.
    task automatic streamFrame(input int ready_pct, input int mid_start_at,
                               input logic [34:0] mid_segs, input int abort_at,
                               input int budget);
        int         n;
        logic       have_prev;
        logic [7:0] prev_data;
        logic       prev_ps;
        n                  = 0;
        byte_cnt           = 0;
        done_sample        = -1;
        last_sample        = -1;
        first_valid_sample = -1;
        stall_viol         = 0;
        aborted            = 1'b0;
        have_prev          = 1'b0;
        prev_data          = 8'd0;
        prev_ps            = 1'b0;
        for (int i = 0; i < 512; i++) begin
            cap_data[i] = 8'hEE;
            cap_ps[i]   = 1'b0;
        end
        while (n < budget) begin
            if (have_prev && data_valid_out &&
                (data_out !== prev_data || page_start_out !== prev_ps)) begin
                stall_viol++;
            end
            if (first_valid_sample < 0 && data_valid_out) first_valid_sample = n;
            if (done_out) begin
                done_sample = n;
                break;
            end
            data_ready_in = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            start_in      = (mid_start_at >= 0 && byte_cnt == mid_start_at);
            if (start_in) segments_in = mid_segs;
            if (abort_at >= 0 && byte_cnt == abort_at) begin
                reset_in = 1'b1;
                tick();
                start_in = 1'b0;
                aborted  = 1'b1;
                break;
            end
            have_prev = data_valid_out && !data_ready_in;
            prev_data = data_out;
            prev_ps   = page_start_out;
            if (data_valid_out && data_ready_in) begin
                if (byte_cnt < 512) begin
                    cap_data[byte_cnt] = data_out;
                    cap_ps[byte_cnt]   = page_start_out;
                end
                if (byte_cnt == 511) last_sample = n;
                byte_cnt++;
            end
            tick();
            n++;
        end
        start_in = 1'b0;
    endtask

    // Compare a captured frame against the reference and check the idle
    // state that must follow the done pulse.
    task automatic evalFrame(input string tag, input logic [34:0] segs);
        int bad_data;
        int bad_ps;
        int first_bad;
        bad_data  = 0;
        bad_ps    = 0;
        first_bad = -1;
        for (int i = 0; i < 512; i++) begin
            if (cap_data[i] !== expByte(i, segs)) begin
                bad_data++;
                if (first_bad < 0) first_bad = i;
            end
            if (cap_ps[i] !== (i % 128 == 0)) bad_ps++;
        end
        checkOutput({tag, " done seen"}, 32'(done_sample >= 0), 32'd1);
        checkOutput({tag, " byte count"}, byte_cnt, 512);
        checkOutput({tag, " bad bytes"}, bad_data, 0);
        if (first_bad >= 0) begin
            checkOutput({tag, " first bad byte"}, cap_data[first_bad], expByte(first_bad, segs));
        end
        checkOutput({tag, " bad page_start"}, bad_ps, 0);
        checkOutput({tag, " stall changes"}, stall_viol, 0);
        tick();
        checkOutput({tag, " done after pulse"}, done_out, 1'b0);
        checkOutput({tag, " busy after frame"}, busy_out, 1'b0);
        checkOutput({tag, " valid after frame"}, data_valid_out, 1'b0);
    endtask

    logic [34:0] segs_zero;
    logic [34:0] segs_d0;
    logic [34:0] segs_d4;
    logic [34:0] segs_mix;
    logic [34:0] segs_all;
    int          idx;

    initial begin
        segs_zero = 35'd0;
        segs_d0   = {28'd0, 7'h3F};
        segs_d4   = {7'h7F, 28'd0};
        segs_mix  = {7'h00, 7'h00, 7'h06, 7'h00, 7'h3F};
        segs_all  = {5{7'h7F}};

        reset_in      = 1'b1;
        start_in      = 1'b0;
        segments_in   = 35'd0;
        data_ready_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;

        // Reset state.
        checkOutput("reset data_out", data_out, 8'd0);
        checkOutput("reset valid", data_valid_out, 1'b0);
        checkOutput("reset page_start", page_start_out, 1'b0);
        checkOutput("reset busy", busy_out, 1'b0);
        checkOutput("reset done", done_out, 1'b0);
        checkOutput("reset seg_out", seg_out, 7'd0);
        checkOutput("reset index_x", index_x_out, 5'd0);
        checkOutput("reset index_y", index_y_out, 2'd0);

        // Ready without valid does nothing while idle.
        data_ready_in = 1'b1;
        tick();
        tick();
        checkOutput("idle ready valid", data_valid_out, 1'b0);
        checkOutput("idle ready busy", busy_out, 1'b0);

        // Case 1: blank digits, full-rate ready, exact timing.
        applyStimulus(segs_zero);
        checkOutput("c1 busy after start", busy_out, 1'b1);
        checkOutput("c1 valid after start", data_valid_out, 1'b1);
        checkOutput("c1 page_start byte0", page_start_out, 1'b1);
        streamFrame(100, -1, segs_zero, -1, 2000);
        checkOutput("c1 first valid sample", first_valid_sample, 0);
        checkOutput("c1 last byte sample", last_sample, 511);
        checkOutput("c1 done sample", done_sample, 512);
        evalFrame("c1", segs_zero);

        // Case 2: digit 0 lit, marker on page 1 columns 5..25.
        applyStimulus(segs_d0);
        streamFrame(100, -1, segs_d0, -1, 2000);
        evalFrame("c2", segs_d0);
        for (int x = 0; x < 21; x++) begin
            checkOutput($sformatf("c2 p1 col %0d", 5 + x), cap_data[128 + 5 + x], 8'hA0 + 8'(x));
        end
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("c2 p1 pad col %0d", c), cap_data[128 + c], 8'd0);
        end
        for (int c = 26; c < 29; c++) begin
            checkOutput($sformatf("c2 p1 gap col %0d", c), cap_data[128 + c], 8'd0);
        end

        // Case 3: only digit 4 lit, columns 101..121 on every page.
        applyStimulus(segs_d4);
        streamFrame(100, -1, segs_d4, -1, 2000);
        evalFrame("c3", segs_d4);
        for (int p = 0; p < 4; p++) begin
            idx = p * 128;
            checkOutput($sformatf("c3 p%0d col 100", p), cap_data[idx + 100], 8'd0);
            checkOutput($sformatf("c3 p%0d col 101", p), cap_data[idx + 101], 8'h80 + 8'(p * 32));
            checkOutput($sformatf("c3 p%0d col 121", p), cap_data[idx + 121], 8'h80 + 8'(p * 32) + 8'd20);
            checkOutput($sformatf("c3 p%0d col 122", p), cap_data[idx + 122], 8'd0);
            checkOutput($sformatf("c3 p%0d col 127", p), cap_data[idx + 127], 8'd0);
        end

        // Case 4: 30% ready duty, stalls must hold data and page_start.
        applyStimulus(segs_mix);
        streamFrame(30, -1, segs_mix, -1, 8000);
        evalFrame("c4", segs_mix);

        // Case 5: start pulsed mid-frame with other digits is ignored.
        applyStimulus(segs_mix);
        streamFrame(100, 100, segs_all, -1, 2000);
        evalFrame("c5", segs_mix);

        // Case 6: reset at byte 200, then a fresh full frame.
        applyStimulus(segs_d0);
        streamFrame(100, -1, segs_d0, 200, 2000);
        checkOutput("c6 aborted", aborted, 1'b1);
        checkOutput("c6 valid after reset", data_valid_out, 1'b0);
        checkOutput("c6 busy after reset", busy_out, 1'b0);
        checkOutput("c6 done after reset", done_out, 1'b0);
        checkOutput("c6 data after reset", data_out, 8'd0);
        reset_in = 1'b0;
        tick();
        applyStimulus(segs_d0);
        checkOutput("c6 restart page_start", page_start_out, 1'b1);
        streamFrame(100, -1, segs_d0, -1, 2000);
        checkOutput("c6 restart done sample", done_sample, 512);
        evalFrame("c6", segs_d0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
